// File: rtl/mult_feeder.sv
// mult_feeder: operand FIFO, single-issue FSM and output register in front of a shift-add multiplier.
// Optional macro MULT_FEEDER_TIMEOUT_EN adds a WAIT watchdog and sticky protocol error flag.
module mult_feeder #(
   parameter int N     = 4,
   parameter int M     = 4,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [N-1:0]             in_a,
   input  logic [M-1:0]             in_b,
   output logic                     data_rdy,
   output logic [N-1:0]             mult1,
   output logic [M-1:0]             mult2,
   input  logic                     result_rdy,
   input  logic [N+M-1:0]           result,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [N+M-1:0]           out_result,
   output logic [$clog2(DEPTH):0]   fill,
   output logic                     err
);

   localparam int AW = $clog2(DEPTH);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_WAIT  = 2'd2;

   logic [1:0]    state;
   logic [N-1:0]  mem_a [DEPTH];
   logic [M-1:0]  mem_b [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   logic          push;
   logic          pop;
   logic          load;
   logic          timeout;

   // Full test is count-based so a same-cycle pop never frees a slot early.
   assign in_ready = (count != (AW+1)'(DEPTH));
   assign push     = in_valid && in_ready;
   assign pop      = (state == S_IDLE) && (count != '0) && (!out_valid || out_ready);
   assign load     = (state == S_WAIT) && result_rdy;
   assign fill     = count;

   always_ff @(posedge clk) begin
      if (push) begin
         mem_a[wr_ptr] <= in_a;
         mem_b[wr_ptr] <= in_b;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= S_IDLE;
         data_rdy <= 1'b0;
         mult1    <= '0;
         mult2    <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (pop) begin
                  mult1    <= mem_a[rd_ptr];
                  mult2    <= mem_b[rd_ptr];
                  data_rdy <= 1'b1;
                  state    <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               data_rdy <= 1'b0;
               state    <= S_WAIT;
            end
            S_WAIT: begin
               if (result_rdy || timeout) state <= S_IDLE;
            end
            default: begin
               data_rdy <= 1'b0;
               state    <= S_IDLE;
            end
         endcase
      end
   end

   // Issue is gated on a free slot, so a load never collides with a held product.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid  <= 1'b0;
         out_result <= '0;
      end else if (load) begin
         out_valid  <= 1'b1;
         out_result <= result;
      end else if (out_valid && out_ready) begin
         out_valid  <= 1'b0;
      end
   end

`ifdef MULT_FEEDER_TIMEOUT_EN
   localparam int TW = $clog2(M + 4) + 1;

   logic [TW-1:0] wait_cnt;

   // Last WAIT cycle is M+3 after entry; err becomes visible at entry+M+4.
   assign timeout = (state == S_WAIT) && !result_rdy && (wait_cnt == TW'(M + 3));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wait_cnt <= '0;
         err      <= 1'b0;
      end else begin
         if (state == S_ISSUE)     wait_cnt <= '0;
         else if (state == S_WAIT) wait_cnt <= wait_cnt + TW'(1);
         if (timeout || (result_rdy && (state != S_WAIT))) err <= 1'b1;
      end
   end
`else
   assign timeout = 1'b0;
   assign err     = 1'b0;
`endif

endmodule

// File: tb/tb_mult_feeder.sv
// Scoreboard bench for mult_feeder with a behavioural shift-add multiplier (M+1 cycle latency).
// Build with MULT_FEEDER_TIMEOUT_EN to exercise the watchdog; otherwise WAIT must hold forever.
module tb_mult_feeder;

   localparam int N     = 4;
   localparam int M     = 4;
   localparam int DEPTH = 4;
   localparam int AW    = 2;
`ifdef MULT_FEEDER_TIMEOUT_EN
   localparam logic STUB_ERR = 1'b1;
`else
   localparam logic STUB_ERR = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             in_valid, in_ready;
   logic [N-1:0]     in_a;
   logic [M-1:0]     in_b;
   logic             data_rdy;
   logic [N-1:0]     mult1;
   logic [M-1:0]     mult2;
   logic             result_rdy;
   logic [N+M-1:0]   result;
   logic             out_valid, out_ready;
   logic [N+M-1:0]   out_result;
   logic [AW:0]      fill;
   logic             err;

   int               n_tests = 0;
   int               n_fail  = 0;
   int unsigned      cyc     = 0;
   int unsigned      n_out   = 0;
   int unsigned      issue_cyc = 0;
   logic             prev_dr = 1'b0;
   logic             prev_ov = 1'b0;
   logic [N+M-1:0]   exp_q[$];
   int unsigned      ov_rise[$];

   mult_feeder #(.N(N), .M(M), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
      .data_rdy(data_rdy), .mult1(mult1), .mult2(mult2),
      .result_rdy(result_rdy), .result(result),
      .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
      .fill(fill), .err(err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Multiplier model: result_rdy pulses M+1 cycles after data_rdy; stub controls override it.
   logic             model_rdy, stub_rdy, stub_mute;
   logic [N+M-1:0]   model_res;
   int unsigned      mcnt;
   logic [N-1:0]     ma;
   logic [M-1:0]     mb;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         model_rdy <= 1'b0;
         model_res <= '0;
         mcnt      <= 0;
         ma        <= '0;
         mb        <= '0;
      end else begin
         model_rdy <= 1'b0;
         if (data_rdy) begin
            mcnt <= M;
            ma   <= mult1;
            mb   <= mult2;
         end else if (mcnt != 0) begin
            mcnt <= mcnt - 1;
            if (mcnt == 1 && !stub_mute) begin
               model_rdy <= 1'b1;
               model_res <= (N+M)'(ma) * (N+M)'(mb);
            end
         end
      end
   end

   assign result_rdy = model_rdy | stub_rdy;
   assign result     = stub_rdy ? 8'hAA : model_res;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Monitor samples mid-cycle what the next rising edge will act on.
   always @(negedge clk) begin
      if (rst) begin
         prev_dr = 1'b0;
         prev_ov = 1'b0;
      end else begin
         if (in_valid && in_ready) exp_q.push_back((N+M)'(in_a) * (N+M)'(in_b));
         if (data_rdy) begin
            check("dr_single_pulse", prev_dr, 0);
            issue_cyc = cyc;
         end
         if (out_valid && !prev_ov) begin
            check("latency", cyc - issue_cyc, M + 2);
            ov_rise.push_back(cyc);
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) check("spurious_out", out_valid, 0);
            else                   check("product", out_result, exp_q.pop_front());
            n_out++;
         end
         prev_dr = data_rdy;
         prev_ov = out_valid;
      end
   end

   task automatic push(input logic [N-1:0] a, input logic [M-1:0] b, output int unsigned stalls);
      logic ok;
      stalls   = 0;
      in_a     = a;
      in_b     = b;
      in_valid = 1'b1;
      forever begin
         @(negedge clk);
         ok = in_ready;
         @(posedge clk); #1;
         if (ok) break;
         stalls++;
         if (stalls > 200) begin
            check("push_timeout", ok, 1);
            break;
         end
      end
      in_valid = 1'b0;
   endtask

   task automatic try_push_once(input logic [N-1:0] a, input logic [M-1:0] b);
      in_a     = a;
      in_b     = b;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_drain(input string tag);
      int unsigned t = 0;
      logic done = 1'b0;
      while (!done && t < 300) begin
         @(posedge clk); #1;
         t++;
         done = (exp_q.size() == 0) && (fill == 0) && !out_valid && !data_rdy;
      end
      check(tag, done, 1);
   endtask

   task automatic wait_high(input int sel, input string tag);
      int unsigned t = 0;
      logic hit = 1'b0;
      while (!hit && t < 100) begin
         @(posedge clk); #1;
         t++;
         case (sel)
            0:       hit = data_rdy;
            1:       hit = out_valid;
            default: hit = err;
         endcase
      end
      if (!hit) check(tag, hit, 1);
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      rst = 1'b1;
      exp_q.delete();
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   logic [N-1:0]   t2_a [4] = '{4'd15, 4'd0, 4'd1, 4'd8};
   logic [M-1:0]   t2_b [4] = '{4'd15, 4'd9, 4'd1, 4'd2};
   logic [N-1:0]   t3_a [5] = '{4'd6, 4'd2, 4'd13, 4'd4, 4'd10};
   logic [M-1:0]   t3_b [5] = '{4'd7, 4'd3, 4'd11, 4'd4, 4'd12};

   initial begin
      int unsigned st;
      int unsigned base;
      int unsigned t0;
      in_valid  = 1'b0;
      in_a      = '0;
      in_b      = '0;
      out_ready = 1'b1;
      stub_rdy  = 1'b0;
      stub_mute = 1'b0;
      #1 rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("rst_in_ready",   in_ready,   1);
      check("rst_data_rdy",   data_rdy,   0);
      check("rst_out_valid",  out_valid,  0);
      check("rst_fill",       fill,       0);
      check("rst_err",        err,        0);
      check("rst_out_result", out_result, 0);
      rst = 1'b0;

      // Single pair
      push(4'd3, 4'd5, st);
      wait_drain("t1_drain");
      check("t1_n_out", n_out, 1);
      check("t1_fill", fill, 0);

      // Back-to-back pairs, one product every M+3 cycles
      ov_rise.delete();
      base = n_out;
      for (int i = 0; i < 4; i++) begin
         push(t2_a[i], t2_b[i], st);
         check("t2_no_stall", st, 0);
      end
      wait_drain("t2_drain");
      check("t2_n_out", n_out - base, 4);
      check("t2_rises", ov_rise.size(), 4);
      for (int i = 1; i < ov_rise.size(); i++) check("t2_spacing", ov_rise[i] - ov_rise[i-1], M + 3);

      // Downstream stalled: FIFO fills, sixth pair refused
      out_ready = 1'b0;
      base = n_out;
      for (int i = 0; i < 5; i++) begin
         push(t3_a[i], t3_b[i], st);
         check("t3_no_stall", st, 0);
      end
      check("t3_fill_full", fill, 4);
      check("t3_in_ready", in_ready, 0);
      try_push_once(4'd9, 4'd9);
      check("t3_refused_fill", fill, 4);
      wait_high(1, "t3_ov_timeout");
      check("t3_held", out_result, 42);
      repeat (3) @(posedge clk);
      #1;
      check("t3_hold_fill", fill, 4);
      check("t3_hold_dr", data_rdy, 0);
      check("t3_hold_ov", out_valid, 1);

      // Full FIFO: pop and refused push in the same cycle
      out_ready = 1'b1;
      in_a      = 4'd5;
      in_b      = 4'd5;
      in_valid  = 1'b1;
      @(posedge clk); #1;
      in_valid  = 1'b0;
      check("t4_fill", fill, 3);
      check("t4_in_ready", in_ready, 1);
      wait_drain("t3_drain");
      check("t3_n_out", n_out - base, 5);

      // Reset while in WAIT with a pair still buffered
      push(4'd9, 4'd3, st);
      push(4'd1, 4'd1, st);
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      exp_q.delete();
      @(posedge clk); #1;
      check("t5_in_ready",  in_ready,   1);
      check("t5_data_rdy",  data_rdy,   0);
      check("t5_mult1",     mult1,      0);
      check("t5_mult2",     mult2,      0);
      check("t5_out_valid", out_valid,  0);
      check("t5_out_res",   out_result, 0);
      check("t5_fill",      fill,       0);
      rst  = 1'b0;
      base = n_out;
      push(4'd2, 4'd7, st);
      wait_drain("t5_drain");
      check("t5_n_out", n_out - base, 1);

      // result_rdy outside WAIT must not disturb the output register
      @(posedge clk); #1;
      stub_rdy = 1'b1;
      @(posedge clk); #1;
      stub_rdy = 1'b0;
      check("stub_out_valid", out_valid,  0);
      check("stub_out_res",   out_result, 14);
      check("stub_err",       err,        STUB_ERR);

`ifdef MULT_FEEDER_TIMEOUT_EN
      do_reset();
      check("t6_err_clear", err, 0);
      stub_mute = 1'b1;
      push(4'd3, 4'd3, st);
      wait_high(0, "t6_dr_timeout");
      t0 = cyc;
      wait_high(2, "t6_err_timeout");
      check("t6_err_latency", cyc - t0, M + 5);
      check("t6_fill", fill, 0);
      if (exp_q.size() != 0) void'(exp_q.pop_front());
      stub_mute = 1'b0;
      base = n_out;
      push(4'd2, 4'd2, st);
      wait_drain("t6_drain");
      check("t6_n_out", n_out - base, 1);
      check("t6_err_sticky", err, 1);
`else
      stub_mute = 1'b1;
      push(4'd3, 4'd3, st);
      repeat (20) @(posedge clk);
      #1;
      check("hold_out_valid", out_valid, 0);
      check("hold_err", err, 0);
      check("hold_fill", fill, 0);
      stub_mute = 1'b0;
      do_reset();
      base = n_out;
      push(4'd2, 4'd2, st);
      wait_drain("hold_drain");
      check("hold_n_out", n_out - base, 1);
`endif

      check("sb_left", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
